// File: rtl/bf2_pkg.sv
// Shared constants and types for the radix-2 butterfly bundle pipeline.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bf2_pkg;

    localparam int BF2_WIDTH = 15;  // default input component width
    localparam int BF2_LANES = 8;   // default butterflies per beat

    // One complex value at result width (input width + 1) for the default build.
    typedef struct packed {
        logic signed [BF2_WIDTH:0] r;
        logic signed [BF2_WIDTH:0] q;
    } bf2_cplx_t;

endpackage

// File: rtl/bf2_lane_core.sv
// One complex butterfly lane: optional -j on operand 2, add/sub, optional halving.
// Latency: 0 cycles, purely combinational.
// Backpressure: none, the enclosing pipeline owns all registers and handshakes.
// Ports: r1/q1, r2/q2 operands; twist, scale controls; r_add/r_sub/q_add/q_sub results.
// Config: BF2_BUNDLE_ROUND_EN selects round-half-up halving instead of truncation.
module bf2_lane_core
    import bf2_pkg::*;
#(
    parameter int WIDTH = BF2_WIDTH
) (
    input  logic signed [WIDTH-1:0] r1,
    input  logic signed [WIDTH-1:0] q1,
    input  logic signed [WIDTH-1:0] r2,
    input  logic signed [WIDTH-1:0] q2,
    input  logic                    twist,
    input  logic                    scale,
    output logic signed [WIDTH:0]   r_add,
    output logic signed [WIDTH:0]   r_sub,
    output logic signed [WIDTH:0]   q_add,
    output logic signed [WIDTH:0]   q_sub
);

    logic signed [WIDTH:0] r1x, q1x, r2x, q2x;
    logic signed [WIDTH:0] r2t, q2t;

    // Halve a full-width sum; rounding needs one extra bit so sum+1 cannot wrap.
    function automatic logic signed [WIDTH:0] halve(input logic signed [WIDTH:0] s,
                                                    input logic sc);
        logic signed [WIDTH+1:0] t;
        begin
`ifdef BF2_BUNDLE_ROUND_EN
            t = {s[WIDTH], s} + {{(WIDTH+1){1'b0}}, 1'b1};
`else
            t = {s[WIDTH], s};
`endif
            halve = sc ? t[WIDTH+1:1] : s;
        end
    endfunction

    always_comb begin
        r1x = {r1[WIDTH-1], r1};
        q1x = {q1[WIDTH-1], q1};
        r2x = {r2[WIDTH-1], r2};
        q2x = {q2[WIDTH-1], q2};
        // Multiplying by -j maps (R, Q) to (Q, -R); -R of the most negative
        // input still fits because negation happens at WIDTH+1 bits.
        if (twist) begin
            r2t = q2x;
            q2t = -r2x;
        end else begin
            r2t = r2x;
            q2t = q2x;
        end
        r_add = halve(r1x + r2t, scale);
        r_sub = halve(r1x - r2t, scale);
        q_add = halve(q1x + q2t, scale);
        q_sub = halve(q1x - q2t, scale);
    end

endmodule

// File: rtl/bf2_bundle_pipe.sv
// LANES parallel complex butterflies behind a 2-stage valid/ready pipeline.
// Latency: 2 cycles from input accept to out_valid; one beat per cycle sustained.
// Backpressure: out_ready=0 stalls S2, a full stalled S2 stalls S1, then in_ready drops.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with din_R/Q_1/2, twist, scale;
//        out_valid/out_ready with dout_R/Q_add/sub.
// Config: BF2_BUNDLE_ROUND_EN (in bf2_lane_core) selects rounding when scale=1.
module bf2_bundle_pipe
    import bf2_pkg::*;
#(
    parameter int WIDTH = BF2_WIDTH,
    parameter int LANES = BF2_LANES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] din_R_1 [LANES],
    input  logic signed [WIDTH-1:0] din_Q_1 [LANES],
    input  logic signed [WIDTH-1:0] din_R_2 [LANES],
    input  logic signed [WIDTH-1:0] din_Q_2 [LANES],
    input  logic                    twist,
    input  logic                    scale,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH:0]   dout_R_add [LANES],
    output logic signed [WIDTH:0]   dout_R_sub [LANES],
    output logic signed [WIDTH:0]   dout_Q_add [LANES],
    output logic signed [WIDTH:0]   dout_Q_sub [LANES]
);

    logic                    s1_vld;
    logic                    s1_twist, s1_scale;
    logic signed [WIDTH-1:0] s1_r1 [LANES];
    logic signed [WIDTH-1:0] s1_q1 [LANES];
    logic signed [WIDTH-1:0] s1_r2 [LANES];
    logic signed [WIDTH-1:0] s1_q2 [LANES];

    logic signed [WIDTH:0]   c_r_add [LANES];
    logic signed [WIDTH:0]   c_r_sub [LANES];
    logic signed [WIDTH:0]   c_q_add [LANES];
    logic signed [WIDTH:0]   c_q_sub [LANES];

    logic s1_adv, s2_adv;

    // S1 may move into S2 in the same cycle that S2 drains, so a full pipe
    // keeps streaming at one beat per cycle.
    assign s2_adv   = out_ready | ~out_valid;
    assign s1_adv   = s2_adv | ~s1_vld;
    assign in_ready = s1_adv;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        bf2_lane_core #(.WIDTH(WIDTH)) u_core (
            .r1    (s1_r1[g]),
            .q1    (s1_q1[g]),
            .r2    (s1_r2[g]),
            .q2    (s1_q2[g]),
            .twist (s1_twist),
            .scale (s1_scale),
            .r_add (c_r_add[g]),
            .r_sub (c_r_sub[g]),
            .q_add (c_q_add[g]),
            .q_sub (c_q_sub[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld    <= 1'b0;
            s1_twist  <= 1'b0;
            s1_scale  <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_r1[i]      <= '0;
                s1_q1[i]      <= '0;
                s1_r2[i]      <= '0;
                s1_q2[i]      <= '0;
                dout_R_add[i] <= '0;
                dout_R_sub[i] <= '0;
                dout_Q_add[i] <= '0;
                dout_Q_sub[i] <= '0;
            end
        end else begin
            // Data registers load only with a real beat; bubbles keep old data.
            if (s1_adv) begin
                s1_vld <= in_valid;
                if (in_valid) begin
                    s1_twist <= twist;
                    s1_scale <= scale;
                    for (int i = 0; i < LANES; i++) begin
                        s1_r1[i] <= din_R_1[i];
                        s1_q1[i] <= din_Q_1[i];
                        s1_r2[i] <= din_R_2[i];
                        s1_q2[i] <= din_Q_2[i];
                    end
                end
            end
            if (s2_adv) begin
                out_valid <= s1_vld;
                if (s1_vld) begin
                    for (int i = 0; i < LANES; i++) begin
                        dout_R_add[i] <= c_r_add[i];
                        dout_R_sub[i] <= c_r_sub[i];
                        dout_Q_add[i] <= c_q_add[i];
                        dout_Q_sub[i] <= c_q_sub[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bf2_bundle_pipe.sv
module tb_bf2_bundle_pipe;
    import bf2_pkg::*;

    localparam int W = BF2_WIDTH;
    localparam int L = BF2_LANES;

    typedef struct packed {
        bf2_cplx_t [L-1:0] add;
        bf2_cplx_t [L-1:0] sub;
    } beat_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, twist, scale, out_valid, out_ready;
    logic signed [W-1:0] din_R_1 [L];
    logic signed [W-1:0] din_Q_1 [L];
    logic signed [W-1:0] din_R_2 [L];
    logic signed [W-1:0] din_Q_2 [L];
    logic signed [W:0]   dout_R_add [L];
    logic signed [W:0]   dout_R_sub [L];
    logic signed [W:0]   dout_Q_add [L];
    logic signed [W:0]   dout_Q_sub [L];

    int    tests_run = 0;
    int    tests_failed = 0;
    int    emitted = 0;
    bit    acc;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    bf2_bundle_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .din_R_1(din_R_1), .din_Q_1(din_Q_1), .din_R_2(din_R_2), .din_Q_2(din_Q_2),
        .twist(twist), .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
        .dout_R_add(dout_R_add), .dout_R_sub(dout_R_sub),
        .dout_Q_add(dout_Q_add), .dout_Q_sub(dout_Q_sub)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic int half(input int s);
`ifdef BF2_BUNDLE_ROUND_EN
        return (s + 1) >>> 1;
`else
        return s >>> 1;
`endif
    endfunction

    // Reference: complex butterfly a +/- b' with b' = b*(-j) when twist.
    function automatic beat_t model();
        beat_t b;
        int r1, q1, br, bq, ra, rs, qa, qs;
        for (int i = 0; i < L; i++) begin
            r1 = din_R_1[i];
            q1 = din_Q_1[i];
            br = twist ? int'(din_Q_2[i]) : int'(din_R_2[i]);
            bq = twist ? -int'(din_R_2[i]) : int'(din_Q_2[i]);
            ra = r1 + br; rs = r1 - br; qa = q1 + bq; qs = q1 - bq;
            if (scale) begin
                ra = half(ra); rs = half(rs); qa = half(qa); qs = half(qs);
            end
            b.add[i].r = ra[W:0]; b.sub[i].r = rs[W:0];
            b.add[i].q = qa[W:0]; b.sub[i].q = qs[W:0];
        end
        return b;
    endfunction

    task automatic rand_data();
        for (int i = 0; i < L; i++) begin
            din_R_1[i] = W'($urandom);
            din_Q_1[i] = W'($urandom);
            din_R_2[i] = W'($urandom);
            din_Q_2[i] = W'($urandom);
        end
    endtask

    // Called at a negedge with inputs set; scores this cycle, returns at next negedge.
    task automatic tick();
        beat_t e;
        #1;
        acc = 1'b0;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", 1, 0);
            end else begin
                e = exp_q[0];
                for (int i = 0; i < L; i++) begin
                    check("sb_r_add", dout_R_add[i], e.add[i].r);
                    check("sb_r_sub", dout_R_sub[i], e.sub[i].r);
                    check("sb_q_add", dout_Q_add[i], e.add[i].q);
                    check("sb_q_sub", dout_Q_sub[i], e.sub[i].q);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    emitted++;
                end
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model());
            acc = 1'b1;
        end
        @(negedge clk);
    endtask

    // Single beat through an empty pipe; returns at the negedge where it is visible.
    task automatic directed(input int r1, input int q1, input int r2, input int q2,
                            input bit tw, input bit sc);
        rand_data();
        din_R_1[0] = W'(r1); din_Q_1[0] = W'(q1);
        din_R_2[0] = W'(r2); din_Q_2[0] = W'(q2);
        twist = tw; scale = sc; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        check("dir_out_valid", out_valid, 1);
    endtask

    task automatic drain();
        int budget;
        in_valid = 1'b0; out_ready = 1'b1;
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            tick();
            budget++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int sent, start_emit, cyc;
        bit saw_block;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; twist = 1'b0; scale = 1'b0;
        rand_data();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_dout_r_add0", dout_R_add[0], 0);
        check("rst_dout_q_sub7", dout_Q_sub[L-1], 0);
        @(negedge clk);

        // Basic beat
        directed(100, -5, 30, 7, 1'b0, 1'b0);
        check("basic_r_add", dout_R_add[0], 130);
        check("basic_r_sub", dout_R_sub[0], 70);
        check("basic_q_add", dout_Q_add[0], 2);
        check("basic_q_sub", dout_Q_sub[0], -12);
        tick();

        // Twist
        directed(10, 20, 3, 4, 1'b1, 1'b0);
        check("twist_r_add", dout_R_add[0], 14);
        check("twist_r_sub", dout_R_sub[0], 6);
        check("twist_q_add", dout_Q_add[0], 17);
        check("twist_q_sub", dout_Q_sub[0], 23);
        tick();

        // Extremes
        directed(-16384, 16383, 16383, -16384, 1'b1, 1'b0);
        check("ext_r_add", dout_R_add[0], -32768);
        check("ext_r_sub", dout_R_sub[0], 0);
        check("ext_q_add", dout_Q_add[0], 0);
        check("ext_q_sub", dout_Q_sub[0], 32766);
        tick();
        directed(-16384, 16383, 16383, -16384, 1'b0, 1'b1);
`ifdef BF2_BUNDLE_ROUND_EN
        check("ext_scale_r_sub", dout_R_sub[0], -16383);
`else
        check("ext_scale_r_sub", dout_R_sub[0], -16384);
`endif
        tick();

        // Backpressure: 6 beats, out_ready low for cycles 3-6
        sent = 0; cyc = 0; saw_block = 1'b0; start_emit = emitted;
        while ((sent < 6 || exp_q.size() != 0) && cyc < 40) begin
            in_valid = (sent < 6);
            out_ready = !(cyc >= 3 && cyc <= 6);
            twist = 1'($urandom); scale = 1'($urandom);
            rand_data();
            #1;
            if (in_valid && !in_ready) saw_block = 1'b1;
            tick();
            if (acc) sent++;
            cyc++;
        end
        check("bp_in_ready_fell", saw_block, 1);
        check("bp_emitted", emitted - start_emit, 6);
        check("bp_queue_empty", exp_q.size(), 0);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            in_valid = 1'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            twist = 1'($urandom); scale = 1'($urandom);
            rand_data();
            tick();
        end
        drain();

        // Reset with two beats in flight
        out_ready = 1'b1;
        in_valid = 1'b1; rand_data(); tick();
        in_valid = 1'b1; rand_data(); tick();
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        for (int i = 0; i < L; i++) begin
            check("mid_rst_r_add", dout_R_add[i], 0);
            check("mid_rst_r_sub", dout_R_sub[i], 0);
            check("mid_rst_q_add", dout_Q_add[i], 0);
            check("mid_rst_q_sub", dout_Q_sub[i], 0);
        end
        for (int n = 0; n < 5; n++) begin
            #1;
            check("flushed_not_emitted", out_valid, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
